// File: rtl/seg_capture.sv
// seg_capture: recovers four 7-segment digit patterns and a brightness level
// from a multiplexed display driver. It watches the active-low digit enables,
// measures how long each digit stays enabled, and commits a digit only when
// the slot looks clean. Frame alignment restarts at digit 0 after errors or
// a long idle period.
module seg_capture #(
  parameter int IDLE_TO = 32
) (
  input  logic       p625,
  input  logic       rst,
  input  logic [6:0] num,
  input  logic [3:0] en,
  output logic [6:0] num1,
  output logic [6:0] num2,
  output logic [6:0] num3,
  output logic [6:0] num4,
  output logic [1:0] light,
  output logic       frame_valid,
  output logic       err
);

  localparam int IDLE_W = $clog2(IDLE_TO + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TO);
  localparam logic [IDLE_W-1:0] IDLE_HIT = IDLE_W'(IDLE_TO - 1);

  // committed outputs and frame alignment
  logic [6:0]        r_digit [4];
  logic [1:0]        r_light;
  logic              r_frame_valid;
  logic              r_err;
  logic [1:0]        r_next_idx;

  // run tracker: describes the single-digit enable currently in progress
  logic              r_run_active;
  logic [1:0]        r_run_idx;
  logic [3:0]        r_run_len;
  logic              r_run_ovf;
  logic [6:0]        r_run_seg;
  logic              r_run_stable;

  logic [IDLE_W-1:0] r_idle_cnt;

  // enable classification
  logic [3:0] w_low;
  logic       w_off;
  logic       w_single;
  logic       w_multi;
  logic [1:0] w_k;
  logic       w_continue;
  logic       w_run_end;
  logic       w_run_good;
  logic       w_idle_hit;

  // commit decisions
  logic       w_digit_we;
  logic [1:0] w_light_next;
  logic [1:0] w_next_idx_next;
  logic       w_fv_next;
  logic       w_err_next;

  assign w_low    = ~en;
  assign w_off    = (w_low == 4'd0);
  // a single low bit means w_low is a power of two
  assign w_single = !w_off && ((w_low & (w_low - 4'd1)) == 4'd0);
  assign w_multi  = !w_off && !w_single;

  // index of the enabled digit (only meaningful for a single enable)
  always_comb begin
    w_k = 2'd3;
    case (w_low)
      4'b0001: w_k = 2'd0;
      4'b0010: w_k = 2'd1;
      4'b0100: w_k = 2'd2;
      default: w_k = 2'd3;
    endcase
  end

  assign w_continue = r_run_active && w_single && (w_k == r_run_idx);
  assign w_run_end  = r_run_active && !w_continue;
  // accepted lengths 3,7,11,15 are exactly those with both low bits set
  assign w_run_good = (r_run_len[1:0] == 2'b11) && !r_run_ovf && r_run_stable;
  assign w_idle_hit = w_off && (r_idle_cnt == IDLE_HIT);

  // decide what an ending run (or a multi-enable cycle) does to the outputs
  always_comb begin
    w_digit_we      = 1'b0;
    w_light_next    = r_light;
    w_next_idx_next = r_next_idx;
    w_fv_next       = 1'b0;
    w_err_next      = 1'b0;
    if (w_multi) begin
      // overlapping enables: the slot is unusable, realign from digit 0
      w_err_next      = 1'b1;
      w_next_idx_next = 2'd0;
    end else if (w_run_end) begin
      if (!w_run_good) begin
        w_err_next = 1'b1;
      end else if (r_run_idx == r_next_idx) begin
        w_digit_we      = 1'b1;
        w_light_next    = r_run_len[3:2];
        w_next_idx_next = r_next_idx + 2'd1;
        w_fv_next       = (r_run_idx == 2'd3);
      end else begin
        // out of order; a digit 0 is still a valid frame start
        w_err_next = 1'b1;
        if (r_run_idx == 2'd0) begin
          w_digit_we      = 1'b1;
          w_light_next    = r_run_len[3:2];
          w_next_idx_next = 2'd1;
        end else begin
          w_next_idx_next = 2'd0;
        end
      end
    end
    if (w_idle_hit) begin
      w_next_idx_next = 2'd0;
    end
  end

  // register committed digits, brightness, pulses and alignment
  always_ff @(posedge p625) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_digit[i] <= 7'h00;
      end
      r_light       <= 2'd0;
      r_frame_valid <= 1'b0;
      r_err         <= 1'b0;
      r_next_idx    <= 2'd0;
    end else begin
      if (w_digit_we) begin
        r_digit[r_run_idx] <= r_run_seg;
      end
      r_light       <= w_light_next;
      r_frame_valid <= w_fv_next;
      r_err         <= w_err_next;
      r_next_idx    <= w_next_idx_next;
    end
  end

  // track the current run: start, extend (saturating length), or end
  always_ff @(posedge p625) begin
    if (rst) begin
      r_run_active <= 1'b0;
      r_run_idx    <= 2'd0;
      r_run_len    <= 4'd0;
      r_run_ovf    <= 1'b0;
      r_run_seg    <= 7'h00;
      r_run_stable <= 1'b0;
    end else if (w_continue) begin
      if (r_run_len == 4'd15) begin
        r_run_ovf <= 1'b1;
      end else begin
        r_run_len <= r_run_len + 4'd1;
      end
      if (num != r_run_seg) begin
        r_run_stable <= 1'b0;
      end
      r_run_seg <= num;
    end else if (w_single) begin
      r_run_active <= 1'b1;
      r_run_idx    <= w_k;
      r_run_len    <= 4'd1;
      r_run_ovf    <= 1'b0;
      r_run_seg    <= num;
      r_run_stable <= 1'b1;
    end else begin
      r_run_active <= 1'b0;
    end
  end

  // count consecutive all-off cycles, saturating at the idle timeout
  always_ff @(posedge p625) begin
    if (rst) begin
      r_idle_cnt <= '0;
    end else if (!w_off) begin
      r_idle_cnt <= '0;
    end else if (r_idle_cnt != IDLE_MAX) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  assign num1        = r_digit[0];
  assign num2        = r_digit[1];
  assign num3        = r_digit[2];
  assign num4        = r_digit[3];
  assign light       = r_light;
  assign frame_valid = r_frame_valid;
  assign err         = r_err;

endmodule

// File: tb/tb_seg_capture.sv
// Testbench for seg_capture: a fixed vector table, hand-written corner
// sequences and a randomized run mix, all checked against a slot-level model.
module tb_seg_capture;

  localparam int IDLE_TO = 32;

  logic       p625;
  logic       rst;
  logic [6:0] num;
  logic [3:0] en;
  logic [6:0] num1, num2, num3, num4;
  logic [1:0] light;
  logic       frame_valid;
  logic       err;

  seg_capture #(.IDLE_TO(IDLE_TO)) dut (
    .p625(p625), .rst(rst), .num(num), .en(en),
    .num1(num1), .num2(num2), .num3(num3), .num4(num4),
    .light(light), .frame_valid(frame_valid), .err(err)
  );

  initial p625 = 1'b0;
  always #5 p625 = ~p625;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int fv_cnt, err_cnt, fv_last, fv_prev;

  // model: a run is the list of patterns seen while one digit stays enabled
  logic [6:0] m_dig [4];
  logic [1:0] m_light;
  bit         m_fv, m_err;
  int         m_next, m_k, m_idle;
  logic [6:0] run_q [$];

  task automatic model_commit(input int len);
    m_dig[m_k] = run_q[len-1];
    m_light    = 2'((len - 3) / 4);
  endtask

  task automatic model_step(input logic r, input logic [3:0] e, input logic [6:0] n);
    int  nlow, k, len;
    bit  cont, ended, good;
    m_fv  = 0;
    m_err = 0;
    if (r) begin
      for (int i = 0; i < 4; i++) m_dig[i] = 7'h00;
      m_light = 0; m_next = 0; m_idle = 0; m_k = 0;
      run_q.delete();
      return;
    end
    nlow = $countones(~e);
    k = -1;
    for (int i = 0; i < 4; i++) if (!e[i]) k = i;
    cont  = (run_q.size() > 0) && (nlow == 1) && (k == m_k);
    ended = (run_q.size() > 0) && !cont;
    if (nlow >= 2) begin
      m_err  = 1;
      m_next = 0;
    end else if (ended) begin
      len  = run_q.size();
      good = (len == 3) || (len == 7) || (len == 11) || (len == 15);
      foreach (run_q[i]) if (run_q[i] != run_q[0]) good = 0;
      if (!good) begin
        m_err = 1;
      end else if (m_k == m_next) begin
        model_commit(len);
        m_fv   = (m_k == 3);
        m_next = (m_next + 1) % 4;
      end else begin
        m_err = 1;
        if (m_k == 0) begin
          model_commit(len);
          m_next = 1;
        end else begin
          m_next = 0;
        end
      end
    end
    if (nlow == 0) begin
      m_idle++;
      if (m_idle == IDLE_TO) m_next = 0;
    end else begin
      m_idle = 0;
    end
    if (cont) begin
      run_q.push_back(n);
    end else if (nlow == 1) begin
      run_q.delete();
      run_q.push_back(n);
      m_k = k;
    end else begin
      run_q.delete();
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // one clock: drive, let the edge happen, then compare all outputs with the model
  task automatic step(input logic r, input logic [3:0] e, input logic [6:0] n);
    logic [31:0] got, exp;
    rst = r; en = e; num = n;
    @(posedge p625);
    model_step(r, e, n);
    #1;
    cyc++;
    got = {num1, num2, num3, num4, light, frame_valid, err};
    exp = {m_dig[0], m_dig[1], m_dig[2], m_dig[3], m_light, m_fv, m_err};
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL cycle%0d outputs: got %h expected %h", cyc, got, exp);
    end
    if (frame_valid) begin
      fv_cnt++;
      fv_prev = fv_last;
      fv_last = cyc;
    end
    if (err) err_cnt++;
  endtask

  task automatic clear_counts();
    fv_cnt = 0; err_cnt = 0; fv_last = 0; fv_prev = 0;
  endtask

  task automatic do_reset();
    step(1'b1, 4'hF, 7'h00);
    step(1'b0, 4'hF, 7'h00);
  endtask

  task automatic run_digit(input int d, input int len, input int gap, input logic [6:0] pat);
    logic [3:0] e;
    e = ~(4'b0001 << d);
    for (int c = 0; c < len; c++) step(1'b0, e, pat);
    for (int c = 0; c < gap; c++) step(1'b0, 4'hF, 7'h00);
  endtask

  task automatic run_frame(input int len, input int gap, input logic [27:0] pats);
    for (int d = 0; d < 4; d++) run_digit(d, len, gap, pats[d*7 +: 7]);
  endtask

  typedef struct {
    logic       r;
    logic [3:0] e;
    logic [6:0] n;
    logic [6:0] x_num1;
    logic [1:0] x_light;
    logic       x_fv;
    logic       x_err;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic r, input logic [3:0] e, input logic [6:0] n,
                     input logic [6:0] xn1, input logic [1:0] xl, input logic xfv,
                     input logic xerr);
    vec_t v;
    v.r = r; v.e = e; v.n = n;
    v.x_num1 = xn1; v.x_light = xl; v.x_fv = xfv; v.x_err = xerr;
    tbl.push_back(v);
  endtask

  localparam logic [27:0] PATS_A = {7'h66, 7'h4F, 7'h5B, 7'h06};
  localparam logic [27:0] PATS_B = {7'h7F, 7'h6D, 7'h3F, 7'h77};

  initial begin
    rst = 1'b1; en = 4'hF; num = 7'h00;
    clear_counts();

    // vector table: long run, unstable run, multi enable, out-of-order digit
    add(1, 4'hF, 7'h00, 7'h00, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 4'hE, 7'h11, 7'h00, 0, 0, 0);
    add(0, 4'hF, 7'h00, 7'h00, 0, 0, 1);
    add(0, 4'hF, 7'h00, 7'h00, 0, 0, 0);
    add(0, 4'hE, 7'h22, 7'h00, 0, 0, 0);
    add(0, 4'hE, 7'h23, 7'h00, 0, 0, 0);
    add(0, 4'hE, 7'h23, 7'h00, 0, 0, 0);
    add(0, 4'hF, 7'h00, 7'h00, 0, 0, 1);
    add(0, 4'hF, 7'h00, 7'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 4'hE, 7'h3F, 7'h00, 0, 0, 0);
    add(0, 4'hF, 7'h00, 7'h3F, 0, 0, 0);
    add(0, 4'hC, 7'h00, 7'h3F, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 4'hD, 7'h06, 7'h3F, 0, 0, 0);
    add(0, 4'hF, 7'h00, 7'h3F, 0, 0, 1);
    add(0, 4'hF, 7'h00, 7'h3F, 0, 0, 0);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].e, tbl[i].n);
      chk($sformatf("vec%0d", i), int'({num1, light, frame_valid, err}),
          int'({tbl[i].x_num1, tbl[i].x_light, tbl[i].x_fv, tbl[i].x_err}));
    end
    chk("vec_num2_untouched", int'(num2), 0);

    // steady driver at brightness 1: 7 on + 9 off per digit, 64 cycles per frame
    do_reset();
    clear_counts();
    for (int f = 0; f < 3; f++) run_frame(7, 9, PATS_A);
    chk("drv_num1", int'(num1), 'h06);
    chk("drv_num2", int'(num2), 'h5B);
    chk("drv_num3", int'(num3), 'h4F);
    chk("drv_num4", int'(num4), 'h66);
    chk("drv_light", int'(light), 1);
    chk("drv_fv_count", fv_cnt, 3);
    chk("drv_fv_period", fv_last - fv_prev, 64);
    chk("drv_err_count", err_cnt, 0);

    // out-of-order digit 3 at length 15, then a digit-0 restart at length 11
    do_reset();
    clear_counts();
    run_digit(0, 3, 1, 7'h11);
    run_digit(1, 3, 1, 7'h22);
    run_digit(3, 15, 1, 7'h44);
    chk("ooo_err", int'(err), 1);
    chk("ooo_num4", int'(num4), 0);
    chk("ooo_fv_count", fv_cnt, 0);
    run_digit(0, 11, 1, 7'h55);
    chk("restart_num1", int'(num1), 'h55);
    chk("restart_light", int'(light), 2);

    // idle timeout realigns to digit 0 without an error
    do_reset();
    clear_counts();
    run_digit(0, 3, 1, 7'h01);
    run_digit(1, 3, 32, 7'h02);
    chk("idle_err_none", err_cnt, 0);
    run_frame(3, 1, PATS_B);
    chk("idle_err_count", err_cnt, 0);
    chk("idle_fv_count", fv_cnt, 1);
    chk("idle_light", int'(light), 0);
    chk("idle_num3", int'(num3), 'h6D);

    // reset during the 5th cycle of a 7-cycle run
    do_reset();
    clear_counts();
    run_frame(3, 1, PATS_A);
    for (int c = 0; c < 4; c++) step(1'b0, 4'hE, 7'h33);
    step(1'b1, 4'hE, 7'h33);
    chk("rst_outputs_zero", int'({num1, num2, num3, num4, light, frame_valid, err}), 0);
    step(1'b0, 4'hF, 7'h00);
    chk("rst_no_err", int'(err), 0);
    clear_counts();
    run_frame(7, 2, PATS_B);
    chk("post_rst_num1", int'(num1), 'h77);
    chk("post_rst_num4", int'(num4), 'h7F);
    chk("post_rst_fv", fv_cnt, 1);
    chk("post_rst_err", err_cnt, 0);

    // randomized mix of runs, glitches, multi enables and idle gaps
    do_reset();
    for (int s = 0; s < 300; s++) begin
      int         mode, d, len, gap;
      bit         glitch;
      logic [6:0] pat;
      logic [3:0] mv, e;
      mode = $urandom_range(0, 99);
      if (mode < 8) begin
        do mv = 4'($urandom_range(0, 15)); while ($countones(mv) < 2);
        step(1'b0, ~mv, 7'($urandom_range(0, 127)));
      end else if (mode < 12) begin
        gap = $urandom_range(25, 40);
        for (int c = 0; c < gap; c++) step(1'b0, 4'hF, 7'h00);
      end else begin
        d      = ($urandom_range(0, 99) < 60) ? m_next : $urandom_range(0, 3);
        len    = ($urandom_range(0, 99) < 70) ? 4 * $urandom_range(0, 3) + 3
                                              : $urandom_range(1, 18);
        glitch = ($urandom_range(0, 99) < 10);
        pat    = 7'($urandom_range(0, 127));
        e      = ~(4'b0001 << d);
        for (int c = 0; c < len; c++)
          step(1'b0, e, (glitch && c == len / 2 && c > 0) ? (pat ^ 7'h01) : pat);
        gap = $urandom_range(0, 3);
        for (int c = 0; c < gap; c++) step(1'b0, 4'hF, 7'h00);
      end
    end
    step(1'b0, 4'hF, 7'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 SHALL have parameter IDLE_TO, default 32; the number of consecutive all-off en cycles after which frame alignment is dropped.
REQ-002 SHALL have port p625, input, 1 bit; the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; synchronous, active-high reset.
REQ-004 SHALL have port num, input, 7 bits; multiplexed segment pattern from the display driver.
REQ-005 SHALL have port en, input, 4 bits; active-low digit enables, bit k selects digit k.
REQ-006 SHALL have ports num1, num2, num3, num4, output, 7 bits each; last committed pattern of digits 0..3.
REQ-007 SHALL have port light, output, 2 bits; brightness level decoded from the last accepted slot.
REQ-008 SHALL have port frame_valid, output, 1 bit; one-cycle pulse when digits 0,1,2,3 have been committed in order.
REQ-009 SHALL have port err, output, 1 bit; one-cycle pulse on any rejected slot.

Function
REQ-010 SHALL classify each cycle's en as: off (4'hF), single (exactly one bit low, index k), or multi (two or more bits low).
REQ-011 SHALL define a run as consecutive cycles of single en with the same k, and track run_idx, run_len (4-bit, saturating at 15 with an overflow flag set on the 16th cycle), run_seg (num sampled on the latest run cycle) and run_stable (cleared if num differs from the previous run cycle).
REQ-012 SHALL end a run on the first cycle whose en differs from the run's en; that cycle may itself start a new run (back-to-back single enables with different k).
REQ-013 SHALL accept an ended run only if run_len is in {3,7,11,15}, overflow is clear and run_stable is set; otherwise it SHALL pulse err and commit nothing.
REQ-014 For an accepted run, SHALL decode light as run_len[3:2] (3->0, 7->1, 11->2, 15->3).
REQ-015 SHALL keep next_idx (2 bits, reset 0). Accepted run with run_idx==next_idx: write run_seg to num{run_idx+1}, update light, next_idx := next_idx+1 (wrapping 3->0).
REQ-016 Accepted run with run_idx!=next_idx: pulse err; if run_idx==0, commit it as digit 0 and set next_idx := 1; else commit nothing and set next_idx := 0.
REQ-017 SHALL pulse frame_valid in the cycle after an in-order commit of digit 3.
REQ-018 Commit latency: run ends in cycle N (first differing en); num1..num4, light, frame_valid and err are updated by the edge closing cycle N and are visible in cycle N+1.
REQ-019 A multi en cycle SHALL end any active run as rejected (err pulse), SHALL start no run, and SHALL set next_idx := 0.
REQ-020 An err pulse caused by a bad run and a new run starting in the same cycle SHALL both take effect; at most one err pulse SHALL be generated per ended run.
REQ-021 SHALL count consecutive off cycles (saturating); on reaching IDLE_TO it SHALL set next_idx := 0 with no err; outputs SHALL hold their values.
REQ-022 Digit outputs and light SHALL change only on accepted commits; frame_valid and err SHALL be low in all other cycles.

Reset
REQ-023 While rst is high at a clock edge: num1..num4 := 7'h00, light := 0, frame_valid := 0, err := 0, next_idx := 0, run state cleared, idle counter := 0.
REQ-024 Reset mid-run SHALL discard the run with no err; the first cycle after reset SHALL be treated as having a preceding en of 4'hF.

Verification
REQ-025 Driver with light=1: each digit's en low for 7 cycles, then 9 off cycles, patterns 7'h06,7'h5B,7'h4F,7'h66 -> num1..num4 match, light=1, frame_valid pulses once per 64 cycles, err never asserts.
REQ-026 en=4'b1110 held for 5 cycles then 4'hF -> err pulses once, in the cycle after en returns high; num1 unchanged.
REQ-027 en=4'b1110 for 3 cycles with num changing on cycle 2 -> err pulse, no commit; en=4'b1100 for 1 cycle -> err pulse, next_idx reset to 0.
REQ-028 Digits 0,1 accepted, then a digit-3 run of 15 cycles -> err, no commit, no frame_valid; a following digit-0 run of 11 cycles -> commits num1, light=2.
REQ-029 Digits 0,1 accepted, 32 off cycles, then digits 0..3 of 3 cycles each -> no err, frame_valid pulses, light=0.
REQ-030 rst asserted on the 5th cycle of a 7-cycle run -> all outputs zero next cycle, no err; the next valid frame is captured correctly.
